// File: rtl/time_load_arbiter.sv
// time_load_arbiter: sequences time-load requests from the 24-hour and
// 12-hour setters onto the single load port of the 24-hour clock core.
// 12-hour requests are converted to 24-hour format. Every request is
// range-checked. Each transaction ends with a one-cycle ack to its
// requester, followed by a guard interval before the next grant.
module time_load_arbiter #(
  parameter logic [3:0] GUARD_CYCLES = 4'd2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req24,
  input  logic [4:0] hours24,
  input  logic [5:0] minutes24,
  input  logic       req12,
  input  logic       isPM12,
  input  logic [3:0] hours12,
  input  logic [5:0] minutes12,
  output logic       ack24,
  output logic       ack12,
  output logic       err,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic       busy,
  output logic       last_src
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_LOAD    = 3'd2,
    ST_ACK     = 3'd3,
    ST_GUARD   = 3'd4
  } state_t;

  // 12-hour to 24-hour hours: 12 AM -> 0, 12 PM -> 12, h PM -> h + 12.
  function automatic logic [4:0] conv_12_to_24(input logic is_pm, input logic [3:0] h);
    logic [4:0] h5;
    h5 = {1'b0, h};
    if (h == 4'd12) begin
      conv_12_to_24 = is_pm ? 5'd12 : 5'd0;
    end else if (is_pm) begin
      conv_12_to_24 = h5 + 5'd12;
    end else begin
      conv_12_to_24 = h5;
    end
  endfunction

  // Range check for a 24-hour request.
  function automatic logic valid_24(input logic [4:0] h, input logic [5:0] m);
    valid_24 = (h <= 5'd23) && (m <= 6'd59);
  endfunction

  // Range check for a 12-hour request (hours 1..12).
  function automatic logic valid_12(input logic [3:0] h, input logic [5:0] m);
    valid_12 = (h != 4'd0) && (h <= 4'd12) && (m <= 6'd59);
  endfunction

  state_t     state_r;
  logic       load_r;
  logic       ack24_r;
  logic       ack12_r;
  logic       err_r;
  logic       err_flag_r;
  logic       busy_r;
  logic [4:0] load_hours_r;
  logic [5:0] load_minutes_r;
  logic       last_src_r;
  logic [3:0] guard_r;
  logic       arm24_r;
  logic       arm12_r;

  logic       elig24_s;
  logic       elig12_s;
  logic       grant_s;
  logic       grant_src_s;
  logic       grant24_s;
  logic       grant12_s;
  logic [4:0] cap_hours_s;
  logic [5:0] cap_minutes_s;
  logic       cap_valid_s;

  // Eligibility, tie-break against the previous winner, and the converted/validated data of the granted source.
  always_comb begin
    elig24_s = req24 & arm24_r;
    elig12_s = req12 & arm12_r;
    grant_s  = elig24_s | elig12_s;
    if (elig24_s && elig12_s) begin
      grant_src_s = ~last_src_r;
    end else if (elig12_s) begin
      grant_src_s = 1'b1;
    end else begin
      grant_src_s = 1'b0;
    end
    grant24_s = (state_r == ST_IDLE) & grant_s & ~grant_src_s;
    grant12_s = (state_r == ST_IDLE) & grant_s & grant_src_s;
    if (last_src_r) begin
      cap_hours_s   = conv_12_to_24(isPM12, hours12);
      cap_minutes_s = minutes12;
      cap_valid_s   = valid_12(hours12, minutes12);
    end else begin
      cap_hours_s   = hours24;
      cap_minutes_s = minutes24;
      cap_valid_s   = valid_24(hours24, minutes24);
    end
  end

  // Arm flags: re-armed whenever the request is low, disarmed on grant so a held request is served only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arm24_r <= 1'b1;
      arm12_r <= 1'b1;
    end else begin
      if (!req24) begin
        arm24_r <= 1'b1;
      end else if (grant24_s) begin
        arm24_r <= 1'b0;
      end else begin
        arm24_r <= arm24_r;
      end
      if (!req12) begin
        arm12_r <= 1'b1;
      end else if (grant12_s) begin
        arm12_r <= 1'b0;
      end else begin
        arm12_r <= arm12_r;
      end
    end
  end

  // Transaction FSM: grant, capture/validate, load pulse, ack pulse, guard interval.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= ST_IDLE;
      load_r         <= 1'b0;
      ack24_r        <= 1'b0;
      ack12_r        <= 1'b0;
      err_r          <= 1'b0;
      err_flag_r     <= 1'b0;
      busy_r         <= 1'b0;
      load_hours_r   <= 5'd0;
      load_minutes_r <= 6'd0;
      last_src_r     <= 1'b1;
      guard_r        <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          load_r  <= 1'b0;
          ack24_r <= 1'b0;
          ack12_r <= 1'b0;
          err_r   <= 1'b0;
          if (grant_s) begin
            last_src_r <= grant_src_s;
            busy_r     <= 1'b1;
            state_r    <= ST_CAPTURE;
          end else begin
            busy_r     <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          // Invalid requests leave the previously loaded time untouched.
          err_flag_r <= ~cap_valid_s;
          if (cap_valid_s) begin
            load_r         <= 1'b1;
            load_hours_r   <= cap_hours_s;
            load_minutes_r <= cap_minutes_s;
          end else begin
            load_r         <= 1'b0;
          end
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          load_r  <= 1'b0;
          ack24_r <= ~last_src_r;
          ack12_r <= last_src_r;
          err_r   <= err_flag_r;
          state_r <= ST_ACK;
        end
        ST_ACK: begin
          ack24_r <= 1'b0;
          ack12_r <= 1'b0;
          err_r   <= 1'b0;
          guard_r <= GUARD_CYCLES;
          state_r <= ST_GUARD;
        end
        ST_GUARD: begin
          guard_r <= guard_r - 4'd1;
          if (guard_r <= 4'd1) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_GUARD;
          end
        end
        default: begin
          load_r  <= 1'b0;
          ack24_r <= 1'b0;
          ack12_r <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign load         = load_r;
  assign ack24        = ack24_r;
  assign ack12        = ack12_r;
  assign err          = err_r;
  assign busy         = busy_r;
  assign load_hours   = load_hours_r;
  assign load_minutes = load_minutes_r;
  assign last_src     = last_src_r;

endmodule

// File: tb/tb_time_load_arbiter.sv
// Directed plus randomized bench for time_load_arbiter, checked against a
// behavioural model of the conversion, validation and arbitration rules.
module tb_time_load_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req24 = 1'b0;
  logic [4:0] hours24 = 5'd0;
  logic [5:0] minutes24 = 6'd0;
  logic       req12 = 1'b0;
  logic       isPM12 = 1'b0;
  logic [3:0] hours12 = 4'd0;
  logic [5:0] minutes12 = 6'd0;
  logic       ack24, ack12, err, load, busy, last_src;
  logic [4:0] load_hours;
  logic [5:0] load_minutes;

  int vectors = 0;
  int miscompares = 0;
  int mdl_h = 0;
  int mdl_m = 0;
  bit mdl_last = 1'b1;

  time_load_arbiter #(.GUARD_CYCLES(4'd2)) dut (
    .clk(clk), .reset(reset),
    .req24(req24), .hours24(hours24), .minutes24(minutes24),
    .req12(req12), .isPM12(isPM12), .hours12(hours12), .minutes12(minutes12),
    .ack24(ack24), .ack12(ack12), .err(err), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes),
    .busy(busy), .last_src(last_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: what the requester of src currently asks for.
  task automatic model(input bit src, output bit v, output int h, output int m);
    if (!src) begin
      v = (int'(hours24) < 24) && (int'(minutes24) < 60);
      h = int'(hours24);
      m = int'(minutes24);
    end else begin
      v = (int'(hours12) >= 1) && (int'(hours12) <= 12) && (int'(minutes12) < 60);
      h = (int'(hours12) % 12) + (isPM12 ? 12 : 0);
      m = int'(minutes12);
    end
  endtask

  task automatic set24(input int h, input int m);
    hours24 = 5'(h); minutes24 = 6'(m);
  endtask

  task automatic set12(input bit pm, input int h, input int m);
    isPM12 = pm; hours12 = 4'(h); minutes12 = 6'(m);
  endtask

  // Called at a negedge with the DUT idle and src about to be granted at the next posedge.
  task automatic run_txn(input bit src, input bit drop);
    bit v; int h; int m;
    model(src, v, h, m);
    @(negedge clk);
    chk("cap_busy", 32'(busy), 32'd1);
    chk("cap_last_src", 32'(last_src), 32'(src));
    chk("cap_load", 32'(load), 32'd0);
    mdl_last = src;
    if (v) begin mdl_h = h; mdl_m = m; end
    @(negedge clk);
    chk("load_pulse", 32'(load), 32'(v));
    chk("load_hours", 32'(load_hours), 32'(mdl_h));
    chk("load_minutes", 32'(load_minutes), 32'(mdl_m));
    chk("load_no_ack", 32'({ack24, ack12}), 32'd0);
    @(negedge clk);
    chk("ack24", 32'(ack24), 32'(!src));
    chk("ack12", 32'(ack12), 32'(src));
    chk("err", 32'(err), 32'(!v));
    chk("ack_no_load", 32'(load), 32'd0);
    if (drop) begin
      if (src) req12 = 1'b0; else req24 = 1'b0;
    end
    @(negedge clk);
    chk("guard_busy1", 32'(busy), 32'd1);
    chk("guard_ack_clear", 32'({ack24, ack12, err}), 32'd0);
    @(negedge clk);
    chk("guard_busy2", 32'(busy), 32'd1);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int nloads; int nacks; bit win; int mode;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_load", 32'(load), 32'd0);
    chk("rst_acks", 32'({ack24, ack12, err}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hours", 32'(load_hours), 32'd0);
    chk("rst_minutes", 32'(load_minutes), 32'd0);
    chk("rst_last_src", 32'(last_src), 32'd1);
    reset = 1'b1;

    // 24-hour request 13:45
    set24(13, 45); req24 = 1'b1;
    run_txn(1'b0, 1'b1);

    // 12-hour conversions: 12:05 PM, 12:30 AM, 11:59 PM
    set12(1'b1, 12, 5); req12 = 1'b1; run_txn(1'b1, 1'b1);
    set12(1'b0, 12, 30); req12 = 1'b1; run_txn(1'b1, 1'b1);
    set12(1'b1, 11, 59); req12 = 1'b1; run_txn(1'b1, 1'b1);

    // Simultaneous requests: previous winner was 12-hour, so 24-hour goes first
    set24(10, 20); set12(1'b1, 3, 7); req24 = 1'b1; req12 = 1'b1;
    run_txn(1'b0, 1'b1);
    run_txn(1'b1, 1'b1);

    // Out-of-range requests from each source
    set24(24, 0); req24 = 1'b1; run_txn(1'b0, 1'b1);
    set12(1'b0, 0, 30); req12 = 1'b1; run_txn(1'b1, 1'b1);

    // Held request is served only once; re-arm after a one-cycle drop
    set24(18, 30); req24 = 1'b1; run_txn(1'b0, 1'b0);
    nloads = 0; nacks = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load) nloads++;
      if (ack24) nacks++;
    end
    chk("held_loads", 32'(nloads), 32'd0);
    chk("held_acks", 32'(nacks), 32'd0);
    chk("held_busy", 32'(busy), 32'd0);
    req24 = 1'b0;
    @(negedge clk);
    set24(7, 0); req24 = 1'b1; run_txn(1'b0, 1'b1);

    // Reset asserted during the load cycle aborts the transaction
    set24(5, 10); req24 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_load", 32'(load), 32'd1);
    reset = 1'b0; req24 = 1'b0;
    #1;
    chk("rst_mid_load", 32'(load), 32'd0);
    chk("rst_mid_ack", 32'(ack24), 32'd0);
    chk("rst_mid_hours", 32'(load_hours), 32'd0);
    mdl_h = 0; mdl_m = 0; mdl_last = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_ack", 32'(ack24), 32'd0);
    set24(9, 15); req24 = 1'b1; run_txn(1'b0, 1'b1);

    // Randomized transactions, including out-of-range data and ties
    for (int n = 0; n < 40; n++) begin
      set24(int'($urandom_range(0, 31)), int'($urandom_range(0, 63)));
      set12(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
      mode = int'($urandom_range(0, 2));
      if (mode == 2) begin
        win = ~mdl_last;
        req24 = 1'b1; req12 = 1'b1;
        run_txn(win, 1'b1);
        run_txn(~win, 1'b1);
      end else begin
        if (mode == 1) req12 = 1'b1; else req24 = 1'b1;
        run_txn(1'(mode), 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
